color_mapping_mul_pipe: RTL and testbench
=========================================

COLOR_MAPPING_MUL_PIPE -- requirements
Module: color_mapping_mul_pipe

Interface
REQ-001 SHALL have parameter din0_WIDTH, default 18, width of operand A.
REQ-002 SHALL have parameter din1_WIDTH, default 18, width of operand B.
REQ-003 SHALL have parameter dout_WIDTH, default 36, width of result.
REQ-004 SHALL have parameter NUM_STAGE, default 3, legal 1..4, pipeline depth in cycles.
REQ-005 SHALL have parameter SIGNED, default 0; 0 = both operands unsigned, 1 = both two's-complement.
REQ-006 SHALL have parameter SHIFT, default 0, legal 0..(din0_WIDTH+din1_WIDTH-1), right shift applied to full product.
REQ-007 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-009 SHALL have port in_valid, input, 1, operands valid.
REQ-010 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-011 SHALL have port din0, input, din0_WIDTH, operand A.
REQ-012 SHALL have port din1, input, din1_WIDTH, operand B.
REQ-013 SHALL have port out_valid, output, 1, dout/sat valid.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-015 SHALL have port dout, output, dout_WIDTH, rounded, shifted, saturated product.
REQ-016 SHALL have port sat, output, 1, high when dout was clamped; aligned with dout.

Function
REQ-017 Full product P SHALL be din0_WIDTH+din1_WIDTH bits; zero-extended operands when SIGNED=0, sign-extended when SIGNED=1; no intermediate truncation.
REQ-018 When SHIFT>0, SHALL add 2^(SHIFT-1) to P (round half up, toward +inf), then arithmetic right shift by SHIFT (logical if SIGNED=0); SHIFT=0 passes P unchanged.
REQ-019 Shifted value SHALL be clamped to dout_WIDTH: unsigned to [0, 2^dout_WIDTH-1]; signed to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1]; sat=1 iff clamping occurred.
REQ-020 Rounding addition SHALL use one extra guard bit so the add cannot wrap before saturation.
REQ-021 Pipeline SHALL hold NUM_STAGE register stages, each with a valid bit; multiply in stage 1, round/shift/saturate completed by final stage.
REQ-022 Global advance enable SHALL be adv = !out_valid || out_ready; in_ready SHALL equal adv combinationally.
REQ-023 Transfer in SHALL occur when in_valid && in_ready; out transfer when out_valid && out_ready.
REQ-024 When adv=1 every stage SHALL shift forward one position (valid bit and data); stage 1 loads in_valid-qualified operands, capturing a bubble if in_valid=0.
REQ-025 When adv=0 all stages, dout, sat, out_valid SHALL hold unchanged.
REQ-026 Latency SHALL be exactly NUM_STAGE cycles from input transfer to out_valid with no stall; throughput one result per cycle when out_ready=1.
REQ-027 Results SHALL emerge in acceptance order; none dropped or duplicated under any out_ready pattern.
REQ-028 Simultaneous output transfer and input transfer in one cycle SHALL be legal and lossless.
REQ-029 dout and sat SHALL be driven directly from final-stage registers (no combinational path from din0/din1).

Reset
REQ-030 While reset=1, all stage valid bits, out_valid, dout, sat and all data registers SHALL be 0, asynchronously.
REQ-031 Reset mid-operation SHALL discard all in-flight data; no result from before reset SHALL appear after release.
REQ-032 in_ready SHALL be 1 in the first cycle after reset deasserts (pipeline empty).

Verification
REQ-033 Defaults, din0=0x3FFFF, din1=0x3FFFF, out_ready=1 -> 3 cycles later out_valid=1, dout=0xFFFF80001, sat=0.
REQ-034 SIGNED=1, 18x18, dout_WIDTH=16, SHIFT=8: din0=-100, din1=300 -> dout=-117 (0xFF8B), sat=0; din0=131071, din1=131071 -> dout=0x7FFF, sat=1.
REQ-035 Back-to-back stream of 10 operand pairs, out_ready=1 -> 10 consecutive out_valid cycles, starting NUM_STAGE cycles after first accept, results in order.
REQ-036 Pipeline full, out_ready held 0 for 5 cycles -> in_ready=0, dout stable throughout; on release all queued results drain in order, none lost.
REQ-037 Two items in flight, reset pulsed mid-cycle -> out_valid=0 immediately; after release with in_valid=0 for 10 cycles, out_valid stays 0.
REQ-038 Sweep NUM_STAGE 1..4 with random operands against a reference model -> latency equals NUM_STAGE, all dout/sat bit-exact.

Source files
------------

// File: rtl/color_mapping_mul_pipe.sv
// color_mapping_mul_pipe
//
// Pipelined multiplier with rounding, right shift and saturation, behind a
// valid/ready handshake. The whole pipeline advances as one unit: when the
// final stage holds a result nobody takes, every stage freezes.
//
// Parameters
//   din0_WIDTH / din1_WIDTH : operand widths
//   dout_WIDTH              : result width
//   NUM_STAGE               : pipeline depth in cycles (1..4)
//   SIGNED                  : 0 = unsigned operands, 1 = two's-complement operands
//   SHIFT                   : right shift applied to the full-width product
//
// Ports
//   clk        : clock, all state on rising edge
//   reset      : asynchronous, active-high; clears every stage
//   in_valid   : operands on din0/din1 are valid
//   in_ready   : block accepts operands this cycle (equals the advance enable)
//   din0, din1 : operands
//   out_valid  : dout/sat hold a result
//   out_ready  : downstream takes the result this cycle
//   dout       : rounded, shifted, saturated product (registered)
//   sat        : dout was clamped (registered, aligned with dout)
module color_mapping_mul_pipe #(
    parameter int din0_WIDTH = 18,
    parameter int din1_WIDTH = 18,
    parameter int dout_WIDTH = 36,
    parameter int NUM_STAGE  = 3,
    parameter int SIGNED     = 0,
    parameter int SHIFT      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  sat
);

    // Full product width, plus one guard bit so the rounding add never wraps.
    localparam int PW = din0_WIDTH + din1_WIDTH;
    localparam int EW = PW + 1;

    // Half an LSB of the shifted result; zero when SHIFT is zero.
    localparam logic [EW-1:0] RND = (EW'(1) << SHIFT) >> 1;

    logic                  adv;
    logic [NUM_STAGE-1:0]  valid_reg;
    logic [PW-1:0]         a_ext;
    logic [PW-1:0]         b_ext;
    logic [PW-1:0]         prod_comb;
    logic [PW-1:0]         final_in;
    logic [EW-1:0]         ext_p;
    logic [EW-1:0]         rnd_p;
    logic [EW-1:0]         shf_p;
    logic [dout_WIDTH-1:0] res_next;
    logic                  sat_next;
    logic [dout_WIDTH-1:0] dout_reg;
    logic                  sat_reg;

    // A stalled final stage is the only thing that can hold the pipeline.
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = valid_reg[NUM_STAGE-1];
    assign dout      = dout_reg;
    assign sat       = sat_reg;

    // Operands extended to the full product width, so the low PW bits of the
    // product are exact in both signed and unsigned modes. A bubble carries
    // a zero product so idle stages hold no stale operand data.
    always_comb begin
        a_ext     = {{(PW-din0_WIDTH){(SIGNED != 0) && din0[din0_WIDTH-1]}}, din0};
        b_ext     = {{(PW-din1_WIDTH){(SIGNED != 0) && din1[din1_WIDTH-1]}}, din1};
        prod_comb = in_valid ? (a_ext * b_ext) : '0;
    end

    // Valid bits travel with the data; stage 0 captures a bubble when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
        end else if (adv) begin
            valid_reg[0] <= in_valid;
            for (int i = 1; i < NUM_STAGE; i++) begin
                valid_reg[i] <= valid_reg[i-1];
            end
        end
    end

    // Product registers for every stage except the last; the last stage
    // registers the finished result instead. A single-stage pipeline feeds
    // the combinational product straight into the result register.
    generate
        if (NUM_STAGE == 1) begin : g_direct
            assign final_in = prod_comb;
        end else begin : g_prod
            logic [PW-1:0] prod_reg [NUM_STAGE-1];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < NUM_STAGE-1; i++) begin
                        prod_reg[i] <= '0;
                    end
                end else if (adv) begin
                    prod_reg[0] <= prod_comb;
                    for (int i = 1; i < NUM_STAGE-1; i++) begin
                        prod_reg[i] <= prod_reg[i-1];
                    end
                end
            end

            assign final_in = prod_reg[NUM_STAGE-2];
        end
    endgenerate

    // Round half up, then shift. The signed branch must stay in its own
    // statement so >>> is evaluated in a signed context.
    always_comb begin
        ext_p = {(SIGNED != 0) && final_in[PW-1], final_in};
        rnd_p = ext_p + RND;
        if (SIGNED != 0) begin
            shf_p = $signed(rnd_p) >>> SHIFT;
        end else begin
            shf_p = rnd_p >> SHIFT;
        end
    end

    // Clamp to the output range. When the output is at least as wide as the
    // guarded value nothing can overflow, so it is simply extended.
    generate
        if (dout_WIDTH >= EW) begin : g_wide
            always_comb begin
                sat_next = 1'b0;
                if (SIGNED != 0) begin
                    res_next = dout_WIDTH'($signed(shf_p));
                end else begin
                    res_next = dout_WIDTH'(shf_p);
                end
            end
        end else begin : g_clamp
            localparam logic [dout_WIDTH-1:0] SMAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
            localparam logic [dout_WIDTH-1:0] SMIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

            always_comb begin
                res_next = shf_p[dout_WIDTH-1:0];
                sat_next = 1'b0;
                if (SIGNED != 0) begin
                    // In range only if every bit from the output sign bit up
                    // is a copy of the sign.
                    if (!(&shf_p[EW-1:dout_WIDTH-1]) && (|shf_p[EW-1:dout_WIDTH-1])) begin
                        sat_next = 1'b1;
                        res_next = shf_p[EW-1] ? SMIN : SMAX;
                    end
                end else begin
                    if (|shf_p[EW-1:dout_WIDTH]) begin
                        sat_next = 1'b1;
                        res_next = '1;
                    end
                end
            end
        end
    endgenerate

    // Final stage: result and flag held while the pipeline is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_reg <= '0;
            sat_reg  <= 1'b0;
        end else if (adv) begin
            dout_reg <= res_next;
            sat_reg  <= sat_next;
        end
    end

endmodule

// File: tb/tb_color_mapping_mul_pipe.sv
// Testbench for color_mapping_mul_pipe.
//
// Four instances cover NUM_STAGE 1..4 with different sign/shift/width
// settings and share one stimulus stream. Each instance has its own
// scoreboard filled from an arithmetic reference model whenever it accepts
// operands, and drained whenever it delivers a result.
module tb_color_mapping_mul_pipe;

    localparam int NI = 4;
    localparam int NS_P [NI] = '{3, 1, 2, 4};
    localparam int SG_P [NI] = '{0, 1, 0, 1};
    localparam int SH_P [NI] = '{0, 8, 5, 3};
    localparam int DW_P [NI] = '{36, 16, 24, 30};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic                 in_valid;
    logic                 out_ready;
    logic [17:0]          din0;
    logic [17:0]          din1;
    logic [NI-1:0]        in_ready_v;
    logic [NI-1:0]        out_valid_v;
    logic [NI-1:0]        sat_v;
    logic [NI-1:0][63:0]  dout_v;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            logic [DW_P[gi]-1:0] d;

            color_mapping_mul_pipe #(
                .din0_WIDTH(18),
                .din1_WIDTH(18),
                .dout_WIDTH(DW_P[gi]),
                .NUM_STAGE (NS_P[gi]),
                .SIGNED    (SG_P[gi]),
                .SHIFT     (SH_P[gi])
            ) u_dut (
                .clk      (clk),
                .reset    (reset),
                .in_valid (in_valid),
                .in_ready (in_ready_v[gi]),
                .din0     (din0),
                .din1     (din1),
                .out_valid(out_valid_v[gi]),
                .out_ready(out_ready),
                .dout     (d),
                .sat      (sat_v[gi])
            );

            assign dout_v[gi] = 64'(d);
        end
    endgenerate

    typedef struct {
        logic [63:0] d;
        logic        s;
        int          cyc;
    } exp_t;

    exp_t        sb [NI][$];
    int          n_out [NI];
    int          last_stall [NI];
    logic [63:0] snap [NI];
    int          base [NI];
    int          cyc;
    int          checks;
    int          errors;

    // Reference: exact integer product, round half up, floor shift, clamp.
    function automatic void model(input int k, input logic [17:0] a, input logic [17:0] b,
                                  output logic [63:0] d, output logic s);
        longint pa, pb, p, lo, hi;
        if (SG_P[k] != 0) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'(a);
            pb = longint'(b);
        end
        p = pa * pb;
        if (SH_P[k] > 0) begin
            p = (p + (longint'(1) <<< (SH_P[k] - 1))) >>> SH_P[k];
        end
        if (SG_P[k] != 0) begin
            hi = (longint'(1) <<< (DW_P[k] - 1)) - 1;
            lo = -hi - 1;
        end else begin
            lo = 0;
            hi = (longint'(1) <<< DW_P[k]) - 1;
        end
        s = (p > hi) || (p < lo);
        if (p > hi) p = hi;
        else if (p < lo) p = lo;
        d = 64'(p) & ((64'd1 << DW_P[k]) - 64'd1);
    endfunction

    function automatic logic [17:0] rand_op();
        logic [17:0] corners [4];
        int          w;
        int          v;
        logic [31:0] r;
        corners[0] = 18'h00000;
        corners[1] = 18'h1FFFF;
        corners[2] = 18'h20000;
        corners[3] = 18'h3FFFF;
        case ($urandom_range(0, 3))
            0: r = $urandom;
            1: r = 32'(corners[$urandom_range(0, 3)]);
            default: begin
                w = int'($urandom_range(1, 12));
                v = int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
                r = 32'(v);
            end
        endcase
        return r[17:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Observes handshakes at the falling edge, i.e. the values that the
    // next rising edge will act on.
    task automatic monitor();
        exp_t        e;
        logic [63:0] d;
        logic        s;
        if (reset) return;
        for (int k = 0; k < NI; k++) begin
            if (out_valid_v[k] && !out_ready) last_stall[k] = cyc;
            if (out_valid_v[k] && out_ready) begin
                check($sformatf("out_pending_i%0d", k), 64'(sb[k].size() != 0), 64'd1);
                if (sb[k].size() != 0) begin
                    e = sb[k].pop_front();
                    n_out[k]++;
                    $display("cyc %0d inst %0d out dout=0x%0h sat=%0d", cyc, k, dout_v[k], sat_v[k]);
                    check($sformatf("dout_i%0d", k), dout_v[k], e.d);
                    check($sformatf("sat_i%0d", k), 64'(sat_v[k]), 64'(e.s));
                    if (last_stall[k] < e.cyc) begin
                        check($sformatf("latency_i%0d", k), 64'(cyc - e.cyc), 64'(NS_P[k]));
                    end
                end
            end
            if (in_valid && in_ready_v[k]) begin
                model(k, din0, din1, d, s);
                e.d   = d;
                e.s   = s;
                e.cyc = cyc;
                sb[k].push_back(e);
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        din0      = '0;
        din1      = '0;
        for (int k = 0; k < NI; k++) begin
            n_out[k]      = 0;
            last_stall[k] = -1;
        end

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_out_valid_i%0d", k), 64'(out_valid_v[k]), 64'd0);
            check($sformatf("rst_dout_i%0d", k), dout_v[k], 64'd0);
            check($sformatf("rst_sat_i%0d", k), 64'(sat_v[k]), 64'd0);
        end
        reset = 1'b0;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("post_rst_in_ready_i%0d", k), 64'(in_ready_v[k]), 64'd1);
        end

        // Largest unsigned product, three-stage default instance.
        din0     = 18'h3FFFF;
        din1     = 18'h3FFFF;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        check("max_unsigned_early_valid", 64'(out_valid_v[0]), 64'd0);
        cycle();
        check("max_unsigned_valid", 64'(out_valid_v[0]), 64'd1);
        check("max_unsigned_dout", dout_v[0], 64'hF_FFF8_0001);
        check("max_unsigned_sat", 64'(sat_v[0]), 64'd0);
        repeat (5) cycle();

        // Signed rounding and positive saturation, single-stage instance.
        din0     = 18'h3FF9C;   // -100
        din1     = 18'd300;
        in_valid = 1'b1;
        cycle();
        check("signed_round_valid", 64'(out_valid_v[1]), 64'd1);
        check("signed_round_dout", dout_v[1], 64'hFF8B);
        check("signed_round_sat", 64'(sat_v[1]), 64'd0);
        din0 = 18'd131071;
        din1 = 18'd131071;
        cycle();
        check("signed_sat_dout", dout_v[1], 64'h7FFF);
        check("signed_sat_sat", 64'(sat_v[1]), 64'd1);
        in_valid = 1'b0;
        repeat (6) cycle();

        // Back-to-back stream of ten pairs.
        for (int k = 0; k < NI; k++) base[k] = n_out[k];
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din0 = rand_op();
            din1 = rand_op();
            cycle();
        end
        in_valid = 1'b0;
        repeat (8) cycle();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("stream_count_i%0d", k), 64'(n_out[k] - base[k]), 64'd10);
        end

        // Fill the pipeline against a stalled consumer, then drain.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din0 = rand_op();
            din1 = rand_op();
            cycle();
        end
        for (int k = 0; k < NI; k++) snap[k] = dout_v[k];
        for (int i = 0; i < 5; i++) begin
            din0 = rand_op();
            din1 = rand_op();
            cycle();
            for (int k = 0; k < NI; k++) begin
                check($sformatf("stall_in_ready_i%0d", k), 64'(in_ready_v[k]), 64'd0);
                check($sformatf("stall_out_valid_i%0d", k), 64'(out_valid_v[k]), 64'd1);
                check($sformatf("stall_dout_stable_i%0d", k), dout_v[k], snap[k]);
            end
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (10) cycle();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("stall_drained_i%0d", k), 64'(sb[k].size()), 64'd0);
        end

        // Reset in the middle of a cycle with items in flight.
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            din0 = rand_op();
            din1 = rand_op();
            cycle();
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("midrst_out_valid_i%0d", k), 64'(out_valid_v[k]), 64'd0);
            check($sformatf("midrst_dout_i%0d", k), dout_v[k], 64'd0);
            sb[k].delete();
        end
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            for (int k = 0; k < NI; k++) begin
                check($sformatf("after_rst_idle_i%0d", k), 64'(out_valid_v[k]), 64'd0);
            end
        end

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 7);
            din0      = rand_op();
            din1      = rand_op();
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) cycle();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("random_drained_i%0d", k), 64'(sb[k].size()), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
